mips_boot_loader: RTL and testbench
===================================

# mips_boot_loader

Parametrised load-and-run sequencer between a host word stream and the single-cycle MIPS processor. Streams instruction and data words into the processor's instruction and data memories through their init write ports while holding the processor in reset, releases it, then watches the PC for a halt address or a cycle-budget timeout. It replaces hand-driven init writes and fixed-delay runs with a handshaked, self-timed bring-up that can be re-run without reloading.

## Interface
Parameters:
- ADDR_W, 8, width of instruction/data init addresses
- DATA_W, 32, word width
- IMEM_DEPTH, 256, valid instruction addresses 0..IMEM_DEPTH-1
- DMEM_DEPTH, 256, valid data addresses 0..DMEM_DEPTH-1
- SETTLE_CYC, 2, cycles processor stays in reset after load, 1..15
- RUN_LIMIT, 150, max run cycles before timeout, >=1
- HALT_PC, 32'd20, PC value that ends a run

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; reset==0 at an edge clears all state
- ld_valid  in  1  host word valid
- ld_ready  out  1  loader accepts word this cycle
- ld_target  in  1  0 = instruction memory, 1 = data memory
- ld_addr  in  ADDR_W  word address
- ld_data  in  DATA_W  word
- ld_last  in  1  final word of the image
- start  in  1  re-run pulse, honoured only in DONE/TIMEOUT
- pc_in  in  32  processor PC
- instr_write_enable  out  1  to processor instruction init port
- instr_write_addr  out  ADDR_W
- instr_write_data  out  DATA_W
- data_init_write_enable  out  1  to processor data init port
- data_init_addr  out  ADDR_W
- data_init_data  out  DATA_W
- cpu_run  out  1  1 = processor released from reset
- done  out  1  halt PC reached
- timeout  out  1  RUN_LIMIT exhausted
- addr_err  out  1  sticky, an out-of-range word was dropped
- cycle_count  out  16  run cycles of the last/current run

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DONE, TIMEOUT.
- Beat accepted when ld_valid && ld_ready. ld_ready = 1 in IDLE and LOAD only.
- IDLE: first accepted beat -> LOAD (or -> SETTLE if that beat has ld_last).
- LOAD: each accepted beat issues one write; accepted beat with ld_last -> SETTLE.
- Write routing: ld_target selects port; other port's enable stays 0. Address >= depth of target: no write, addr_err set, beat still consumed (ld_last still honoured).
- SETTLE: cpu_run=0, counts SETTLE_CYC cycles, then -> RUN, cycle_count cleared to 0.
- RUN: cpu_run=1; cycle_count increments each cycle, saturating at 16'hFFFF. pc_in==HALT_PC -> DONE; else cycle_count reaching RUN_LIMIT-1 on this cycle -> TIMEOUT. Halt wins when both occur same cycle.
- DONE/TIMEOUT: cpu_run=0, flag held, cycle_count frozen. start -> SETTLE (memories untouched, flags cleared on entry to SETTLE). ld_valid ignored.
- start outside DONE/TIMEOUT ignored.

## Timing
- Reset values: ld_ready=0 during reset cycle then 1 in IDLE; all write enables 0, addrs/data 0, cpu_run 0, done 0, timeout 0, addr_err 0, cycle_count 0; state IDLE.
- Write latency: beat accepted at edge N -> enable high, addr/data stable for exactly the cycle after edge N (captured by memory at edge N+1). Back-to-back beats give back-to-back single-cycle writes; no bubbles.
- Last write completes before SETTLE count starts; cpu_run rises SETTLE_CYC+1 edges after the ld_last beat edge.
- done/timeout assert the edge after the detecting RUN cycle; cpu_run falls the same edge.
- Reset mid-operation (any state): next edge returns to IDLE, cpu_run=0 immediately registered, in-flight write dropped, addr_err cleared.

## Test plan
- Load 6 instr words (addr 0..5, last on 5) with valid held high -> 6 consecutive single-cycle instr_write_enable pulses, addrs 0..5, data match; data_init_write_enable never high; cpu_run rises 3 edges after last beat (SETTLE_CYC=2).
- Mixed stream instr@0, data@100, instr@1 -> writes routed to correct ports in order; data_init_addr=100 with correct data.
- Word at instr addr 300 with IMEM_DEPTH=256 -> no write, addr_err=1 sticky; following beats still written.
- pc_in driven to 20 on 12th RUN cycle -> done=1, cycle_count=11, cpu_run=0; then start -> SETTLE, done=0, rerun without any write pulses.
- pc_in never 20, RUN_LIMIT=150 -> timeout=1 after 150 run cycles, cycle_count=149; done=0. Halt and limit same cycle -> done=1, timeout=0.
- reset=0 during RUN -> next edge cpu_run=0, all outputs reset values, ld_ready=1 after release.

Source files
------------

// File: rtl/mips_boot_loader.sv
// mips_boot_loader
// ----------------
// Load-and-run sequencer for the single-cycle MIPS core. A host streams
// words (valid/ready handshake) that are written into the core's
// instruction or data memory through their init write ports while the core
// is held in reset. After the final word the core stays in reset for a short
// settle period. It is then released, and the loader watches the PC for a
// halt address or for a run-cycle budget to run out. From DONE or TIMEOUT a
// start pulse re-runs the loaded image without reloading it.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   ld_valid/ld_ready          host word handshake (ready in IDLE/LOAD only)
//   ld_target                  0 = instruction memory, 1 = data memory
//   ld_addr, ld_data, ld_last  word address, word, end-of-image marker
//   start                      re-run pulse, honoured in DONE/TIMEOUT
//   pc_in                      processor program counter
//   instr_write_*              instruction memory init write port
//   data_init_*                data memory init write port
//   cpu_run                    1 = processor released from reset
//   done, timeout              run ended by halt PC / by cycle budget
//   addr_err                   sticky: an out-of-range word was dropped
//   cycle_count                run cycles of the last/current run
module mips_boot_loader #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 32,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter int          SETTLE_CYC = 2,
    parameter int          RUN_LIMIT  = 150,
    parameter logic [31:0] HALT_PC    = 32'd20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_target,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              start,
    input  logic [31:0]       pc_in,
    output logic              instr_write_enable,
    output logic [ADDR_W-1:0] instr_write_addr,
    output logic [DATA_W-1:0] instr_write_data,
    output logic              data_init_write_enable,
    output logic [ADDR_W-1:0] data_init_addr,
    output logic [DATA_W-1:0] data_init_data,
    output logic              cpu_run,
    output logic              done,
    output logic              timeout,
    output logic              addr_err,
    output logic [15:0]       cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    // Last cycle_count value of a run that has not halted.
    localparam logic [15:0] LIMIT_CNT  = 16'(RUN_LIMIT - 1);
    localparam logic [3:0]  SETTLE_END = 4'(SETTLE_CYC);

    state_t      state_reg, state_next;
    logic [3:0]  settle_reg, settle_next;
    logic [15:0] count_reg, count_next;
    logic        err_reg, err_next;

    logic        beat;
    logic [1:0]  hit;       // beat routed to port gi and inside its depth
    logic        bad_beat;  // beat consumed but dropped as out of range

    assign ld_ready = reset && ((state_reg == IDLE) || (state_reg == LOAD));
    assign beat     = ld_valid && ld_ready;
    assign bad_beat = beat && (hit == 2'b00);

    // One registered write port per memory: index 0 = instruction, 1 = data.
    // A write is presented for exactly the cycle after the beat is accepted.
    // Address/data hold their last written values between writes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : port_g
            localparam int unsigned DEPTH = (gi == 0) ? IMEM_DEPTH : DMEM_DEPTH;

            logic              en_reg;
            logic [ADDR_W-1:0] addr_reg;
            logic [DATA_W-1:0] data_reg;

            assign hit[gi] = beat && (ld_target == 1'(gi)) &&
                             (32'(ld_addr) < DEPTH);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    en_reg   <= 1'b0;
                    addr_reg <= '0;
                    data_reg <= '0;
                end else begin
                    en_reg <= hit[gi];
                    if (hit[gi]) begin
                        addr_reg <= ld_addr;
                        data_reg <= ld_data;
                    end
                end
            end
        end
    endgenerate

    assign instr_write_enable     = port_g[0].en_reg;
    assign instr_write_addr       = port_g[0].addr_reg;
    assign instr_write_data       = port_g[0].data_reg;
    assign data_init_write_enable = port_g[1].en_reg;
    assign data_init_addr         = port_g[1].addr_reg;
    assign data_init_data         = port_g[1].data_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            settle_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            settle_reg <= settle_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        count_next  = count_reg;
        err_next    = err_reg || bad_beat;

        case (state_reg)
            IDLE: begin
                if (beat) begin
                    state_next  = ld_last ? SETTLE : LOAD;
                    settle_next = '0;
                end
            end
            LOAD: begin
                if (beat && ld_last) begin
                    state_next  = SETTLE;
                    settle_next = '0;
                end
            end
            // The first SETTLE cycle carries the final write, so the core
            // stays in reset for SETTLE_CYC cycles after that write lands.
            SETTLE: begin
                if (settle_reg == SETTLE_END) begin
                    state_next = RUN;
                    count_next = '0;
                end else begin
                    settle_next = settle_reg + 4'd1;
                end
            end
            // The halt check comes first so that it wins over the budget.
            // The count is not advanced on the cycle that ends the run.
            RUN: begin
                if (pc_in == HALT_PC) begin
                    state_next = DONE;
                end else if (count_reg == LIMIT_CNT) begin
                    state_next = TIMEOUT;
                end else if (count_reg != 16'hFFFF) begin
                    count_next = count_reg + 16'd1;
                end
            end
            DONE, TIMEOUT: begin
                if (start) begin
                    state_next  = SETTLE;
                    settle_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_run     = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign timeout     = (state_reg == TIMEOUT);
    assign addr_err    = err_reg;
    assign cycle_count = count_reg;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed testbench for mips_boot_loader. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_mips_boot_loader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid;
    logic          ld_ready;
    logic          ld_target;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          start;
    logic [31:0]   pc_in;
    logic          instr_write_enable;
    logic [AW-1:0] instr_write_addr;
    logic [DW-1:0] instr_write_data;
    logic          data_init_write_enable;
    logic [AW-1:0] data_init_addr;
    logic [DW-1:0] data_init_data;
    logic          cpu_run;
    logic          done;
    logic          timeout;
    logic          addr_err;
    logic [15:0]   cycle_count;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mips_boot_loader #(
        .ADDR_W(AW), .DATA_W(DW), .IMEM_DEPTH(256), .DMEM_DEPTH(256),
        .SETTLE_CYC(2), .RUN_LIMIT(150), .HALT_PC(32'd20)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_target(ld_target),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .start(start), .pc_in(pc_in),
        .instr_write_enable(instr_write_enable),
        .instr_write_addr(instr_write_addr),
        .instr_write_data(instr_write_data),
        .data_init_write_enable(data_init_write_enable),
        .data_init_addr(data_init_addr),
        .data_init_data(data_init_data),
        .cpu_run(cpu_run), .done(done), .timeout(timeout),
        .addr_err(addr_err), .cycle_count(cycle_count)
    );

    task automatic drive_beat(input logic tgt, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic last);
        ld_valid  = 1'b1;
        ld_target = tgt;
        ld_addr   = a;
        ld_data   = d;
        ld_last   = last;
    endtask

    task automatic test_reset();
        reset = 1'b0; ld_valid = 1'b0; ld_target = 1'b0; ld_addr = '0;
        ld_data = '0; ld_last = 1'b0; start = 1'b0; pc_in = 32'd0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ld_ready); end
        vectors++;
        if ({instr_write_enable, data_init_write_enable, cpu_run, done, timeout, addr_err} !== 6'b0)
            begin miscompares++; $display("FAIL reset_flags: got %b expected 000000",
                {instr_write_enable, data_init_write_enable, cpu_run, done, timeout, addr_err}); end
        vectors++;
        if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", cycle_count); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b expected 1", ld_ready); end
        $display("test_reset: ready=%b run=%b count=%0d", ld_ready, cpu_run, cycle_count);
    endtask

    task automatic test_mixed();
        drive_beat(1'b0, 10'd0, 32'h1111_0000, 1'b0);
        @(negedge clk);
        vectors++;
        if (!(instr_write_enable === 1'b1 && instr_write_addr === 10'd0 &&
              instr_write_data === 32'h1111_0000 && data_init_write_enable === 1'b0))
            begin miscompares++; $display("FAIL mixed_i0: got we=%b a=%0d d=%h dwe=%b expected 1 0 11110000 0",
                instr_write_enable, instr_write_addr, instr_write_data, data_init_write_enable); end
        drive_beat(1'b1, 10'd100, 32'hDDDD_0064, 1'b0);
        @(negedge clk);
        vectors++;
        if (!(data_init_write_enable === 1'b1 && data_init_addr === 10'd100 &&
              data_init_data === 32'hDDDD_0064 && instr_write_enable === 1'b0))
            begin miscompares++; $display("FAIL mixed_d100: got dwe=%b a=%0d d=%h iwe=%b expected 1 100 dddd0064 0",
                data_init_write_enable, data_init_addr, data_init_data, instr_write_enable); end
        drive_beat(1'b0, 10'd1, 32'h1111_0001, 1'b0);
        @(negedge clk);
        vectors++;
        if (!(instr_write_enable === 1'b1 && instr_write_addr === 10'd1 &&
              instr_write_data === 32'h1111_0001 && data_init_write_enable === 1'b0))
            begin miscompares++; $display("FAIL mixed_i1: got we=%b a=%0d d=%h dwe=%b expected 1 1 11110001 0",
                instr_write_enable, instr_write_addr, instr_write_data, data_init_write_enable); end
        $display("test_mixed: last instr addr=%0d data addr=%0d", instr_write_addr, data_init_addr);
    endtask

    task automatic test_addr_err();
        drive_beat(1'b0, 10'd300, 32'hBAD0_012C, 1'b0);
        @(negedge clk);
        vectors++;
        if (!(instr_write_enable === 1'b0 && data_init_write_enable === 1'b0 && addr_err === 1'b1))
            begin miscompares++; $display("FAIL err_i300: got iwe=%b dwe=%b err=%b expected 0 0 1",
                instr_write_enable, data_init_write_enable, addr_err); end
        drive_beat(1'b1, 10'd256, 32'hBAD0_0100, 1'b0);
        @(negedge clk);
        vectors++;
        if (!(data_init_write_enable === 1'b0 && instr_write_enable === 1'b0 && addr_err === 1'b1))
            begin miscompares++; $display("FAIL err_d256: got dwe=%b iwe=%b err=%b expected 0 0 1",
                data_init_write_enable, instr_write_enable, addr_err); end
        drive_beat(1'b0, 10'd2, 32'h1111_0002, 1'b1);
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        vectors++;
        if (!(instr_write_enable === 1'b1 && instr_write_addr === 10'd2 &&
              instr_write_data === 32'h1111_0002 && addr_err === 1'b1))
            begin miscompares++; $display("FAIL err_after: got we=%b a=%0d d=%h err=%b expected 1 2 11110002 1",
                instr_write_enable, instr_write_addr, instr_write_data, addr_err); end
        repeat (3) @(negedge clk);
        vectors++;
        if (!(cpu_run === 1'b1 && addr_err === 1'b1))
            begin miscompares++; $display("FAIL err_sticky: got run=%b err=%b expected 1 1", cpu_run, addr_err); end
        $display("test_addr_err: addr_err=%b cpu_run=%b", addr_err, cpu_run);
    endtask

    task automatic test_reset_mid_run();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (!(cpu_run === 1'b0 && ld_ready === 1'b0 && addr_err === 1'b0 && done === 1'b0 && timeout === 1'b0))
            begin miscompares++; $display("FAIL rst_run_flags: got run=%b rdy=%b err=%b done=%b to=%b expected 0 0 0 0 0",
                cpu_run, ld_ready, addr_err, done, timeout); end
        vectors++;
        if (!(cycle_count === 16'd0 && data_init_addr === 10'd0 && instr_write_addr === 10'd0 &&
              data_init_data === 32'd0 && instr_write_enable === 1'b0))
            begin miscompares++; $display("FAIL rst_run_regs: got cnt=%0d da=%0d ia=%0d dd=%h iwe=%b expected 0 0 0 0 0",
                cycle_count, data_init_addr, instr_write_addr, data_init_data, instr_write_enable); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (!(ld_ready === 1'b1 && cpu_run === 1'b0))
            begin miscompares++; $display("FAIL rst_release: got rdy=%b run=%b expected 1 0", ld_ready, cpu_run); end
        $display("test_reset_mid_run: ready=%b run=%b", ld_ready, cpu_run);
    endtask

    task automatic test_instr_load();
        int dwe_seen = 0;
        for (int i = 0; i < 6; i++) begin
            drive_beat(1'b0, AW'(i), 32'hA000_0000 + 32'(i), (i == 5));
            @(negedge clk);
            if (data_init_write_enable) dwe_seen++;
            vectors++;
            if (!(instr_write_enable === 1'b1 && instr_write_addr === AW'(i) &&
                  instr_write_data === 32'hA000_0000 + 32'(i)))
                begin miscompares++; $display("FAIL load_w%0d: got we=%b a=%0d d=%h expected 1 %0d %h",
                    i, instr_write_enable, instr_write_addr, instr_write_data, i, 32'hA000_0000 + 32'(i)); end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        vectors++;
        if (dwe_seen !== 0) begin miscompares++; $display("FAIL load_no_dwe: got %0d data writes expected 0", dwe_seen); end
        @(negedge clk);
        vectors++;
        if (!(cpu_run === 1'b0 && instr_write_enable === 1'b0))
            begin miscompares++; $display("FAIL settle1: got run=%b we=%b expected 0 0", cpu_run, instr_write_enable); end
        @(negedge clk);
        vectors++;
        if (cpu_run !== 1'b0) begin miscompares++; $display("FAIL settle2: got run=%b expected 0", cpu_run); end
        @(negedge clk);
        vectors++;
        if (!(cpu_run === 1'b1 && cycle_count === 16'd0))
            begin miscompares++; $display("FAIL run_rise: got run=%b cnt=%0d expected 1 0", cpu_run, cycle_count); end
        $display("test_instr_load: 6 writes, cpu_run=%b", cpu_run);
    endtask

    task automatic test_halt_rerun();
        repeat (11) @(negedge clk);
        vectors++;
        if (!(cycle_count === 16'd11 && cpu_run === 1'b1))
            begin miscompares++; $display("FAIL run_c12: got cnt=%0d run=%b expected 11 1", cycle_count, cpu_run); end
        pc_in = 32'd20;
        @(negedge clk);
        pc_in = 32'd0;
        vectors++;
        if (!(done === 1'b1 && timeout === 1'b0 && cpu_run === 1'b0 && cycle_count === 16'd11))
            begin miscompares++; $display("FAIL halt: got done=%b to=%b run=%b cnt=%0d expected 1 0 0 11",
                done, timeout, cpu_run, cycle_count); end
        drive_beat(1'b0, 10'd7, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        ld_valid = 1'b0;
        vectors++;
        if (!(instr_write_enable === 1'b0 && ld_ready === 1'b0 && done === 1'b1 && cycle_count === 16'd11))
            begin miscompares++; $display("FAIL done_ignore: got we=%b rdy=%b done=%b cnt=%0d expected 0 0 1 11",
                instr_write_enable, ld_ready, done, cycle_count); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (!(done === 1'b0 && cpu_run === 1'b0 && ld_ready === 1'b0))
            begin miscompares++; $display("FAIL rerun_settle: got done=%b run=%b rdy=%b expected 0 0 0", done, cpu_run, ld_ready); end
        repeat (2) @(negedge clk);
        vectors++;
        if (!(cpu_run === 1'b0 && instr_write_enable === 1'b0 && data_init_write_enable === 1'b0))
            begin miscompares++; $display("FAIL rerun_quiet: got run=%b iwe=%b dwe=%b expected 0 0 0",
                cpu_run, instr_write_enable, data_init_write_enable); end
        @(negedge clk);
        vectors++;
        if (!(cpu_run === 1'b1 && cycle_count === 16'd0))
            begin miscompares++; $display("FAIL rerun_run: got run=%b cnt=%0d expected 1 0", cpu_run, cycle_count); end
        $display("test_halt_rerun: halted at count 11, rerun started");
    endtask

    task automatic test_timeout();
        repeat (148) @(negedge clk);
        vectors++;
        if (!(cycle_count === 16'd148 && timeout === 1'b0 && cpu_run === 1'b1))
            begin miscompares++; $display("FAIL to_c149: got cnt=%0d to=%b run=%b expected 148 0 1", cycle_count, timeout, cpu_run); end
        @(negedge clk);
        vectors++;
        if (!(cycle_count === 16'd149 && cpu_run === 1'b1))
            begin miscompares++; $display("FAIL to_c150: got cnt=%0d run=%b expected 149 1", cycle_count, cpu_run); end
        @(negedge clk);
        vectors++;
        if (!(timeout === 1'b1 && done === 1'b0 && cpu_run === 1'b0 && cycle_count === 16'd149))
            begin miscompares++; $display("FAIL timeout: got to=%b done=%b run=%b cnt=%0d expected 1 0 0 149",
                timeout, done, cpu_run, cycle_count); end
        $display("test_timeout: timeout=%b count=%0d", timeout, cycle_count);
    endtask

    task automatic test_halt_limit();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_clear: got to=%b expected 0", timeout); end
        repeat (3) @(negedge clk);
        repeat (149) @(negedge clk);
        pc_in = 32'd20;
        @(negedge clk);
        pc_in = 32'd0;
        vectors++;
        if (!(done === 1'b1 && timeout === 1'b0 && cycle_count === 16'd149))
            begin miscompares++; $display("FAIL halt_limit: got done=%b to=%b cnt=%0d expected 1 0 149",
                done, timeout, cycle_count); end
        $display("test_halt_limit: done=%b timeout=%b count=%0d", done, timeout, cycle_count);
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_addr_err();
        test_reset_mid_run();
        test_instr_load();
        test_halt_rerun();
        test_timeout();
        test_halt_limit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
